// File: rtl/div_16_pkg.sv
// Shared constants for the ALU's sequential 16-bit datapath units (divider and multiplier).
// Also provides the counter-to-phase decode used by the divider control.
package div_16_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] CNT_IDLE  = 5'd0;
  localparam logic [CNT_W-1:0] CNT_FIRST = 5'd1;
  localparam logic [CNT_W-1:0] CNT_DONE  = 5'd17;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;

  // The shift-add multiplier walks the same 0 / 1..16 / 17 counter sequence.
  localparam logic [CNT_W-1:0] MUL_CNT_IDLE  = 5'd0;
  localparam logic [CNT_W-1:0] MUL_CNT_FIRST = 5'd1;
  localparam logic [CNT_W-1:0] MUL_CNT_DONE  = 5'd17;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_ITER = 2'd1,
    PH_DONE = 2'd2,
    PH_BAD  = 2'd3
  } div_phase_e;

  function automatic div_phase_e div_phase(input logic [CNT_W-1:0] cnt);
    div_phase_e ph;
    if (cnt == CNT_IDLE) begin
      ph = PH_IDLE;
    end else if (cnt < CNT_DONE) begin
      ph = PH_ITER;
    end else if (cnt == CNT_DONE) begin
      ph = PH_DONE;
    end else begin
      ph = PH_BAD;
    end
    return ph;
  endfunction

endpackage

// File: rtl/div_c_16.sv
// Combinational control for div_16: decodes the iteration counter, start request,
// reset and subtractor borrow into datapath enables.
module div_c_16
  import div_16_pkg::*;
(
  input  logic             reset,
  input  logic [CNT_W-1:0] counter,
  input  logic             divOp,
  input  logic             borrow,
  output logic             wr_rem,
  output logic             sl_shift,
  output logic             ld_operands,
  output logic             wr_counter,
  output logic             rt_counter,
  output logic             rt_rem,
  output logic             ready,
  output logic             q_bit
);

  div_phase_e phase;
  logic       start;

  always_comb begin
    phase = div_phase(counter);
    // A new operation may only begin from IDLE or from a finished result.
    start = reset && divOp && ((phase == PH_IDLE) || (phase == PH_DONE));

    ld_operands = start;
    rt_rem      = !reset || start;
    sl_shift    = reset && (phase == PH_ITER);
    wr_rem      = reset && (phase == PH_ITER);
    wr_counter  = start || (reset && (phase == PH_ITER));
    // Unreachable counter values fall back to IDLE on the next edge.
    rt_counter  = !reset || (phase == PH_BAD);
    ready       = (phase == PH_DONE);
    q_bit       = !borrow;
  end

endmodule

// File: rtl/div_16.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock,
// sequenced by a 0..17 counter (0 idle, 1..16 iterate, 17 done).
module div_16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divOp,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ready,
  output logic [CNT_W-1:0] counter
);
  import div_16_pkg::*;

  localparam logic [CNT_W-1:0] CNT_STEP = 1;

  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] counter_q, counter_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             divisor_zero;

  logic wr_rem, sl_shift, ld_operands, wr_counter, rt_counter, rt_rem, q_bit;

  div_c_16 u_ctrl (
    .reset       (reset),
    .counter     (counter_q),
    .divOp       (divOp),
    .borrow      (borrow),
    .wr_rem      (wr_rem),
    .sl_shift    (sl_shift),
    .ld_operands (ld_operands),
    .wr_counter  (wr_counter),
    .rt_counter  (rt_counter),
    .rt_rem      (rt_rem),
    .ready       (ready),
    .q_bit       (q_bit)
  );

  // One extra bit on the subtraction makes the borrow explicit regardless of R's range.
  always_comb begin
    r_shift      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff         = {1'b0, r_shift} - {2'b00, dvs_q};
    trial        = diff[WIDTH:0];
    borrow       = diff[WIDTH+1];
    divisor_zero = (divisor == '0);
  end

  always_comb begin
    r_d       = r_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    dbz_d     = dbz_q;
    counter_d = counter_q;

    if (rt_rem) begin
      r_d = '0;
    end

    if (ld_operands) begin
      dvs_d = divisor;
      q_d   = dividend;
      dbz_d = divisor_zero;
      // A zero divisor skips the iterations and reports the saturated result directly.
      if (divisor_zero) begin
        q_d = DIV0_QUOTIENT;
        r_d = {1'b0, dividend};
      end
    end

    if (sl_shift && wr_rem) begin
      r_d = borrow ? r_shift : trial;
      q_d = {q_q[WIDTH-2:0], q_bit};
    end

    if (wr_counter) begin
      if (ld_operands) begin
        counter_d = divisor_zero ? CNT_DONE : CNT_FIRST;
      end else begin
        counter_d = counter_q + CNT_STEP;
      end
    end

    if (rt_counter) begin
      counter_d = CNT_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q       <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      dbz_q     <= 1'b0;
      counter_q <= CNT_IDLE;
    end else begin
      r_q       <= r_d;
      q_q       <= q_d;
      dvs_q     <= dvs_d;
      dbz_q     <= dbz_d;
      counter_q <= counter_d;
    end
  end

  always_comb begin
    quotient    = q_q;
    remainder   = r_q[WIDTH-1:0];
    div_by_zero = dbz_q;
    counter     = counter_q;
  end

endmodule

// File: tb/tb_div_16.sv
// Directed and random checks of div_16 against a plain-arithmetic division model.
module tb_div_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        divOp;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        ready;
  logic [4:0]  counter;

  int total = 0;
  int bad   = 0;

  div_16 dut (
    .clk         (clk),
    .reset       (reset),
    .divOp       (divOp),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .ready       (ready),
    .counter     (counter)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] eq, er;
    eq = (b == 16'd0) ? 16'hFFFF : a / b;
    er = (b == 16'd0) ? a : a % b;
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, (b == 16'd0));
  endtask

  // Pulse divOp for one edge, scramble the operand inputs, then wait for ready.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n;
    dividend = a;
    divisor  = b;
    divOp    = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        divOp    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
    end while (!ready && n < 40);
    chk({tag, "_lat"}, n, (b == 16'd0) ? 1 : 17);
    check_result(tag, a, b);
  endtask

  initial begin
    int n;
    logic [15:0] a, b;
    logic [31:0] recon;

    reset    = 1'b0;
    divOp    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_counter", counter, 0);
    chk("rst_ready", ready, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    run("d100_7", 16'd100, 16'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ready", ready, 1);
      chk("hold_quot", quotient, 14);
      chk("hold_rem", remainder, 2);
    end

    run("ffff_1", 16'hFFFF, 16'd1);
    run("d3_10", 16'd3, 16'd10);
    run("d5_0", 16'd5, 16'd0);

    // Abort mid-operation with reset.
    dividend = 16'd1000;
    divisor  = 16'd33;
    divOp    = 1'b1;
    step();
    divOp = 1'b0;
    n = 0;
    while (counter != 5'd8 && n < 40) begin
      step();
      n++;
    end
    chk("abort_reach8", counter, 8);
    reset = 1'b0;
    step();
    chk("abort_counter", counter, 0);
    chk("abort_ready", ready, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    reset = 1'b1;
    step();
    run("d1000_33", 16'd1000, 16'd33);

    // divOp held high: result at DONE, then immediate restart on the next edge.
    dividend = 16'd50000;
    divisor  = 16'd123;
    divOp    = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 40);
    chk("held_lat", n, 17);
    check_result("d50000_123", 16'd50000, 16'd123);
    dividend = 16'd9;
    divisor  = 16'd4;
    step();
    divOp = 1'b0;
    chk("restart_ready_drop", ready, 0);
    chk("restart_counter", counter, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 40);
    chk("restart_lat", n, 16);
    check_result("d9_4", 16'd9, 16'd4);

    for (int i = 0; i < 500; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 15));
        1:       b = 16'($urandom_range(0, 255));
        default: b = 16'($urandom);
      endcase
      run("rand", a, b);
      if (b != 16'd0) begin
        recon = 32'(quotient) * 32'(b) + 32'(remainder);
        chk("rand_recon", recon, 32'(a));
        chk("rand_rem_lt", (remainder < b), 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
